// File: rtl/lvds_tx_pkg.sv
// Shared definitions for the LVDS lane TX sequencer and its RX aligner counterpart:
// sequencer states and the default training / sync / idle code words.
package lvds_tx_pkg;

  typedef enum logic [1:0] {
    RST_S  = 2'd0,
    SETTLE = 2'd1,
    TRAIN  = 2'd2,
    ACTIVE = 2'd3
  } lvds_state_e;

  localparam logic [9:0] LVDS_TRAIN_WORD = 10'h3E0;
  localparam logic [9:0] LVDS_SYNC_WORD  = 10'h37C;
  localparam logic [9:0] LVDS_IDLE_WORD  = 10'h000;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/lvds_tx_ctrl.sv
// Power-up / training / streaming sequencer for one LVDS serializer lane,
// clocked by the serializer's divided (parallel-word) clock.
module lvds_tx_ctrl
  import lvds_tx_pkg::*;
#(
  parameter int                    DATA_WIDTH    = 10,
  parameter int                    RST_CYCLES    = 8,
  parameter int                    SETTLE_CYCLES = 16,
  parameter int                    TRAIN_CYCLES  = 256,
  parameter int                    SYNC_PERIOD   = 1024,
  parameter logic [DATA_WIDTH-1:0] TRAIN_WORD    = DATA_WIDTH'(LVDS_TRAIN_WORD),
  parameter logic [DATA_WIDTH-1:0] SYNC_WORD     = DATA_WIDTH'(LVDS_SYNC_WORD),
  parameter logic [DATA_WIDTH-1:0] IDLE_WORD     = DATA_WIDTH'(LVDS_IDLE_WORD)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  retrain,
  output logic                  serdes_rst,
  output logic [DATA_WIDTH-1:0] par_data,
  output logic                  link_up,
  output logic                  sync_slot
);

  localparam int CNT_MAX = max4(RST_CYCLES, SETTLE_CYCLES, TRAIN_CYCLES, SYNC_PERIOD);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TRAIN_LAST  = CNT_W'(TRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] SYNC_LAST   = CNT_W'(SYNC_PERIOD - 1);

  lvds_state_e           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] par_data_q, par_data_d;
  logic                  serdes_rst_q, serdes_rst_d;
  logic                  link_up_q, link_up_d;
  logic                  sync_slot_q, sync_slot_d;

  // Ready never looks at s_valid, so the source cannot form a combinational loop through us.
  assign s_ready = (state_q == ACTIVE) && (cnt_q != '0) && !retrain;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CNT_W'(1);
    par_data_d   = IDLE_WORD;
    serdes_rst_d = 1'b0;
    link_up_d    = 1'b0;
    sync_slot_d  = 1'b0;
    case (state_q)
      RST_S: begin
        serdes_rst_d = 1'b1;
        par_data_d   = '0;
        if (cnt_q == RST_LAST) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end
      end
      SETTLE: begin
        par_data_d = TRAIN_WORD;
        if (cnt_q == SETTLE_LAST) begin
          state_d = TRAIN;
          cnt_d   = '0;
        end
      end
      TRAIN: begin
        par_data_d = TRAIN_WORD;
        if (cnt_q == TRAIN_LAST) begin
          state_d = ACTIVE;
          cnt_d   = '0;
        end
      end
      ACTIVE: begin
        if (cnt_q == '0) begin
          par_data_d  = SYNC_WORD;
          sync_slot_d = 1'b1;
        end else if (retrain) begin
          par_data_d = TRAIN_WORD;
        end else if (s_valid) begin
          par_data_d = s_data;
        end
        if (cnt_q == SYNC_LAST) cnt_d = '0;
        // A retrain request drops the link on this same edge, even in a sync slot.
        if (retrain) begin
          state_d = TRAIN;
          cnt_d   = '0;
        end else begin
          link_up_d = 1'b1;
        end
      end
      default: begin
        state_d = RST_S;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RST_S;
      cnt_q        <= '0;
      par_data_q   <= '0;
      serdes_rst_q <= 1'b1;
      link_up_q    <= 1'b0;
      sync_slot_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      par_data_q   <= par_data_d;
      serdes_rst_q <= serdes_rst_d;
      link_up_q    <= link_up_d;
      sync_slot_q  <= sync_slot_d;
    end
  end

  assign par_data   = par_data_q;
  assign serdes_rst = serdes_rst_q;
  assign link_up    = link_up_q;
  assign sync_slot  = sync_slot_q;

endmodule

// File: tb/tb_lvds_tx_ctrl.sv
// Directed bench for lvds_tx_ctrl: stimulus queues expected outputs per edge, a monitor pops and compares.
module tb_lvds_tx_ctrl;

  typedef struct packed {
    logic [9:0] word;
    logic       srst;
    logic       link;
    logic       sync;
    logic       chk_link;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] s_data = '0;
  logic       s_valid = 1'b0;
  logic       retrain = 1'b0;
  logic       s_ready;
  logic       serdes_rst;
  logic [9:0] par_data;
  logic       link_up;
  logic       sync_slot;

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         slot = 0;
  logic [9:0] dw = 10'd1;
  logic       acc;

  lvds_tx_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .retrain    (retrain),
    .serdes_rst (serdes_rst),
    .par_data   (par_data),
    .link_up    (link_up),
    .sync_slot  (sync_slot)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, required %0h", nm, $time, act, req);
    end
  endtask

  // One clock: drive inputs at the falling edge, check s_ready, queue what the next rising edge must produce.
  task automatic cyc(input logic rst, input logic v, input logic [9:0] d, input logic rt,
                     input int rdy, input logic [9:0] w, input logic srst, input logic lk,
                     input logic sy, input logic cl);
    exp_t e;
    @(negedge clk);
    reset = rst; s_valid = v; s_data = d; retrain = rt;
    #1;
    if (rdy >= 0) chk("s_ready", int'(s_ready), rdy);
    e.word = w; e.srst = srst; e.link = lk; e.sync = sy; e.chk_link = cl;
    sb.push_back(e);
  endtask

  // ACTIVE cycle with no retrain; slot tracks where the sync period stands.
  task automatic act(input logic v, input logic [9:0] d, output logic accepted);
    if (slot == 0) begin
      cyc(1'b0, v, d, 1'b0, 0, 10'h37C, 1'b0, 1'b1, 1'b1, 1'b1);
      accepted = 1'b0;
    end else begin
      cyc(1'b0, v, d, 1'b0, 1, v ? d : 10'h000, 1'b0, 1'b1, 1'b0, 1'b1);
      accepted = v;
    end
    slot = (slot + 1) % 1024;
  endtask

  task automatic powerup();
    for (int k = 0; k < 8; k++)   cyc(1'b0, 1'b0, 10'h0, 1'b0, 0, 10'h000, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 272; k++) cyc(1'b0, 1'b0, 10'h0, 1'b0, 0, 10'h3E0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 10'h0, 1'b0, 0, 10'h37C, 1'b0, 1'b1, 1'b1, 1'b1);
    slot = 1;
  endtask

  task automatic train_tail(input logic [9:0] held);
    for (int k = 0; k < 256; k++) cyc(1'b0, 1'b1, held, 1'b0, 0, 10'h3E0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, held, 1'b0, 0, 10'h37C, 1'b0, 1'b1, 1'b1, 1'b1);
    slot = 1;
  endtask

  initial begin : monitor
    exp_t m;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        m = sb.pop_front();
        chk("par_data", int'(par_data), int'(m.word));
        chk("serdes_rst", int'(serdes_rst), int'(m.srst));
        chk("sync_slot", int'(sync_slot), int'(m.sync));
        if (m.chk_link) chk("link_up", int'(link_up), int'(m.link));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 10'h0, 1'b0, -1, 10'h000, 1'b1, 1'b0, 1'b0, 1'b1);
    powerup();

    // Held valid, incrementing payload across a full sync period.
    for (int i = 0; i < 1025; i++) begin
      act(1'b1, dw, acc);
      if (acc) dw = dw + 10'd1;
    end

    // Valid toggling, crossing a sync slot.
    for (int i = 0; i < 1100; i++) begin
      act(i[0] ? 1'b0 : 1'b1, dw, acc);
      if (acc) dw = dw + 10'd1;
    end

    // Retrain in a data slot: word held by the source, re-emitted after sync.
    cyc(1'b0, 1'b1, dw, 1'b1, 0, 10'h3E0, 1'b0, 1'b0, 1'b0, 1'b1);
    train_tail(dw);
    act(1'b1, dw, acc);
    if (acc) dw = dw + 10'd1;

    // Retrain landing on the sync slot.
    while (slot != 0) begin
      act(1'b1, dw, acc);
      if (acc) dw = dw + 10'd1;
    end
    cyc(1'b0, 1'b1, dw, 1'b1, 0, 10'h37C, 1'b0, 1'b0, 1'b1, 1'b0);
    train_tail(dw);
    for (int i = 0; i < 3; i++) begin
      act(1'b1, dw, acc);
      if (acc) dw = dw + 10'd1;
    end

    // Reset mid-ACTIVE, then the whole power-up sequence again.
    cyc(1'b1, 1'b1, dw, 1'b0, 1, 10'h000, 1'b1, 1'b0, 1'b0, 1'b1);
    dw = dw + 10'd1;
    powerup();
    for (int i = 0; i < 4; i++) begin
      act(1'b1, dw, acc);
      if (acc) dw = dw + 10'd1;
    end

    @(posedge clk);
    #2;
    chk("sb_drain", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
